aucohl_sync_fifo: RTL and testbench

//  Single-clock synchronous FIFO, DW bits wide and 2**AW entries deep.

---
 rtl/aucohl_sync_fifo_pkg.sv | 7 +
 rtl/aucohl_fifo_mem.sv | 29 ++
 rtl/aucohl_sync_fifo.sv | 69 ++++++
 tb/tb_aucohl_sync_fifo.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/aucohl_sync_fifo_pkg.sv
// Shared defaults for the DMA data-buffer FIFO.
package aucohl_sync_fifo_pkg;

  localparam int unsigned DefaultDw = 32;
  localparam int unsigned DefaultAw = 4;

endpackage

// File: rtl/aucohl_fifo_mem.sv
// Register-array storage: synchronous write, asynchronous read.
module aucohl_fifo_mem
  import aucohl_sync_fifo_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0] mem [Depth];

  // Contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/aucohl_sync_fifo.sv
// Single-clock first-word fall-through FIFO with flags, level and synchronous flush.
module aucohl_sync_fifo
  import aucohl_sync_fifo_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic          wr,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic          empty,
  output logic          full,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] level
);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt;
  logic        push, pop;

  assign cnt   = wr_ptr_q - rd_ptr_q;
  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same index, opposite wrap bit: exactly one full lap ahead.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = cnt[AW-1:0];

  assign push = wr && !full && !flush;
  assign pop  = rd && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  aucohl_fifo_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_aucohl_sync_fifo.sv
// Directed and randomized bench for aucohl_sync_fifo against a queue-based model.
module tb_aucohl_sync_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned Depth = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd = 1'b0;
  logic          wr = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          empty, full;
  logic [DW-1:0] rdata;
  logic [AW-1:0] level;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [DW-1:0] model_q[$];

  aucohl_sync_fifo #(
    .DW (DW),
    .AW (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rd    (rd),
    .wr    (wr),
    .flush (flush),
    .wdata (wdata),
    .empty (empty),
    .full  (full),
    .rdata (rdata),
    .level (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    int unsigned sz;
    sz = model_q.size();
    check({tag, ".empty"}, 64'(empty), 64'(sz == 0));
    check({tag, ".full"},  64'(full),  64'(sz == Depth));
    check({tag, ".level"}, 64'(level), 64'(sz % Depth));
    if (sz != 0) check({tag, ".rdata"}, 64'(rdata), 64'(model_q[0]));
  endtask

  // Apply one cycle of stimulus, advance the model by the FIFO rules, then check.
  task automatic step(input string tag, input logic r, input logic w, input logic f,
                      input logic [DW-1:0] d);
    bit do_pop, do_push;
    rd = r; wr = w; flush = f; wdata = d;
    do_pop  = r && (model_q.size() > 0);
    do_push = w && (model_q.size() < Depth);
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    #1;
    check_outputs(tag);
  endtask

  logic [DW-1:0] fill_words [Depth];
  logic [DW-1:0] popped;
  logic [DW-1:0] tmp;

  initial begin
    fill_words[0]  = 32'hAAAA_BBBB; fill_words[1]  = 32'hCCCC_DDDD;
    fill_words[2]  = 32'hEEEE_FFFF; fill_words[3]  = 32'h0000_1111;
    fill_words[4]  = 32'h2222_3333; fill_words[5]  = 32'h4444_5555;
    fill_words[6]  = 32'h6666_7777; fill_words[7]  = 32'h8888_9999;
    fill_words[8]  = 32'h1234_5678; fill_words[9]  = 32'h9ABC_DEF0;
    fill_words[10] = 32'h0F0F_0F0F; fill_words[11] = 32'hF0F0_F0F0;
    fill_words[12] = 32'h5555_AAAA; fill_words[13] = 32'hA5A5_5A5A;
    fill_words[14] = 32'hFEDC_BA98; fill_words[15] = 32'h7654_3210;

    // Reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill to full
    for (int i = 0; i < int'(Depth); i++) step("fill", 1'b0, 1'b1, 1'b0, fill_words[i]);

    // Overflow push ignored, also with rd asserted while full is not involved
    step("overflow", 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);

    // Drain; DEAD_BEEF must never surface
    for (int i = 0; i < int'(Depth); i++) begin
      popped = rdata;
      check("drain.order", 64'(popped), 64'(fill_words[i]));
      step("drain", 1'b1, 1'b0, 1'b0, '0);
    end
    step("underflow", 1'b1, 1'b0, 1'b0, '0);

    // Read while empty with write: only the write occurs
    step("rd_wr_empty", 1'b1, 1'b1, 1'b0, 32'hAAAA_BBBB);

    // Simultaneous access across pointer wrap
    for (int i = 0; i < 20; i++) step("simul", 1'b1, 1'b1, 1'b0, $urandom);

    // Fill to full then push+pop together: write ignored, pop occurs
    while (model_q.size() < Depth) step("refill", 1'b0, 1'b1, 1'b0, $urandom);
    step("full_rdwr", 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);

    // Flush with 5 entries and a concurrent write
    step("pre_flush", 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) step("flush_fill", 1'b0, 1'b1, 1'b0, $urandom);
    step("flush", 1'b1, 1'b1, 1'b1, 32'hBAD0_BAD0);
    tmp = 32'h1357_9BDF;
    step("post_flush", 1'b0, 1'b1, 1'b0, tmp);
    check("post_flush.head", 64'(rdata), 64'(tmp));

    // Randomized traffic with varying bias
    for (int i = 0; i < 600; i++) begin
      int unsigned bias;
      bias = (i / 100) % 3;
      step("rand",
           ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))),
           ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
           ($urandom_range(0, 63) == 0),
           $urandom);
    end

    // Asynchronous reset mid-operation, away from any clock edge
    while (model_q.size() < 3) step("pre_arst", 1'b0, 1'b1, 1'b0, $urandom);
    rd = 1'b0; wr = 1'b0; flush = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("after_arst", 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global timeout guard
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
